// File: rtl/cu_sequencer_if.sv
// Bundles the microinstruction/status inputs and the control-state outputs
// of the microprogram sequencer. The master side is the control ROM /
// status logic; the slave side is the sequencer itself.
interface cu_sequencer_if #(
  parameter int STATE_W  = 7,
  parameter int MAX_WAIT = 16
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [2:0]         n_code;
  logic [1:0]         cond_sel;
  logic               cond_inv;
  logic [3:0]         cond_in;
  logic [STATE_W-1:0] encoder_state;
  logic [STATE_W-1:0] cr_target;
  logic               stall;

  logic [STATE_W-1:0] state;
  logic               waiting;
  logic               timeout;
  logic [CNT_W-1:0]   wait_cnt;

  modport master (
    output n_code, cond_sel, cond_inv, cond_in, encoder_state, cr_target, stall,
    input  state, waiting, timeout, wait_cnt
  );

  modport slave (
    input  n_code, cond_sel, cond_inv, cond_in, encoder_state, cr_target, stall,
    output state, waiting, timeout, wait_cnt
  );
endinterface

// File: rtl/cu_sequencer.sv
// Microprogram sequencer: selects the next control-ROM address from the
// microinstruction's next-state code and a selected condition bit, and
// supervises memory-wait holds with a timeout into an error state.
//
// n_code | meaning
// -------+-----------------------------------------------
// 000    | fetch: go to FETCH_STATE
// 001    | dispatch: go to encoder_state
// 010    | jump: go to cr_target
// 011    | increment: go to state+1 (wraps)
// 100    | cond branch: cond ? cr_target : state+1
// 101    | cond dispatch: cond ? encoder_state : cr_target
// 110    | wait: cond ? state+1 : hold (timeout -> ERR_STATE)
// 111    | cond return: cond ? FETCH_STATE : state+1
module cu_sequencer #(
  parameter int STATE_W     = 7,
  parameter int FETCH_STATE = 0,
  parameter int ERR_STATE   = 127,
  parameter int MAX_WAIT    = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  cu_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [STATE_W-1:0] L_FETCH = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] L_ERR   = STATE_W'(ERR_STATE);
  localparam logic [CNT_W-1:0]   L_LAST  = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    NC_FETCH     = 3'b000,
    NC_DISPATCH  = 3'b001,
    NC_JUMP      = 3'b010,
    NC_INC       = 3'b011,
    NC_CBRANCH   = 3'b100,
    NC_CDISPATCH = 3'b101,
    NC_WAIT      = 3'b110,
    NC_CRETURN   = 3'b111
  } ncode_e;

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_waiting;
  logic               r_timeout;

  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   w_wait_cnt_nxt;
  logic               w_waiting_nxt;
  logic               w_timeout_nxt;
  logic [STATE_W-1:0] w_inc;
  logic               w_cond;
  ncode_e             w_n_code;

  assign w_n_code = ncode_e'(bus.n_code);
  assign w_cond   = bus.cond_in[bus.cond_sel] ^ bus.cond_inv;
  assign w_inc    = r_state + STATE_W'(1);

  // Sequencer registers; reset drops any wait in progress without a timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= L_FETCH;
      r_wait_cnt <= '0;
      r_waiting  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_waiting  <= w_waiting_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state selection; stall freezes everything except the timeout pulse.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_waiting_nxt  = r_waiting;
    w_timeout_nxt  = 1'b0;
    if (!bus.stall) begin
      w_wait_cnt_nxt = '0;
      w_waiting_nxt  = 1'b0;
      case (w_n_code)
        NC_FETCH:     w_state_nxt = L_FETCH;
        NC_DISPATCH:  w_state_nxt = bus.encoder_state;
        NC_JUMP:      w_state_nxt = bus.cr_target;
        NC_INC:       w_state_nxt = w_inc;
        NC_CBRANCH:   w_state_nxt = w_cond ? bus.cr_target : w_inc;
        NC_CDISPATCH: w_state_nxt = w_cond ? bus.encoder_state : bus.cr_target;
        NC_WAIT: begin
          if (w_cond) begin
            w_state_nxt = w_inc;
          end else if (r_wait_cnt == L_LAST) begin
            // Last permitted unsatisfied cycle: abandon the wait.
            w_state_nxt   = L_ERR;
            w_timeout_nxt = 1'b1;
          end else begin
            w_state_nxt    = r_state;
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
            w_waiting_nxt  = 1'b1;
          end
        end
        NC_CRETURN:   w_state_nxt = w_cond ? L_FETCH : w_inc;
        default:      w_state_nxt = L_FETCH;
      endcase
    end
  end

  assign bus.state    = r_state;
  assign bus.wait_cnt = r_wait_cnt;
  assign bus.waiting  = r_waiting;
  assign bus.timeout  = r_timeout;
endmodule
